// File: rtl/conv_data_responder_if.sv
// Bus between the conversion controller / loader / file-writer and conv_data_responder.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high; valid must not wait on ready.
interface conv_data_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              read_data;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [DATA_W-1:0] conv_in;
  logic              store;
  logic              en_c;
  logic [CNT_W-1:0]  cnt;
  logic              write_to_file;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              ovf;
  logic              done;
`ifdef RESP_PARITY_EN
  logic              out_par;
`endif

  modport master (
    output load_valid, load_data, read_data, conv_in, store, en_c, write_to_file, out_ready,
    input  load_ready, data_out, data_valid, cnt, out_valid, out_data, out_last, ovf, done
`ifdef RESP_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  load_valid, load_data, read_data, conv_in, store, en_c, write_to_file, out_ready,
    output load_ready, data_out, data_valid, cnt, out_valid, out_data, out_last, ovf, done
`ifdef RESP_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/conv_data_responder.sv
// Datapath responder for the conversion controller: input buffer, result buffer, item count, result drain stream.
// Optional RESP_PARITY_EN adds out_par (even parity of out_data, registered with it).
module conv_data_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 25,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  conv_data_if.slave bus,
  output logic [1:0] dbgState
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  typedef enum logic [1:0] {LOAD = 2'd0, SERVE = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, nextState;

  logic [DATA_W-1:0] inbuf  [DEPTH];
  logic [DATA_W-1:0] resbuf [DEPTH];

  logic [PTR_W-1:0]  wrPtr;
  logic [IDX_W-1:0]  drainPtr, drainNext, cntIdx, wrIdx;
  logic [CNT_W-1:0]  cntQ;
  logic [PTR_W-1:0]  drainLen;
  logic [DATA_W-1:0] drainWord;
  logic loadFire, inRange, cntZero, serveStrobe, resWrite;
  logic drainStart, outFire, drainEnd, outLoad, firstLast, nextLast;

  assign loadFire    = (state == LOAD) && bus.load_ready && bus.load_valid;
  assign inRange     = cntQ < DEPTH_C;
  assign cntZero     = (cntQ == '0);
  assign cntIdx      = cntQ[IDX_W-1:0];
  assign wrIdx       = wrPtr[IDX_W-1:0];
  // write_to_file wins over any strobe arriving in the same cycle
  assign serveStrobe = (state == SERVE) && !bus.write_to_file;
  assign resWrite    = serveStrobe && bus.store && inRange;
  assign drainStart  = (state == SERVE) && bus.write_to_file;
  assign outFire     = (state == DRAIN) && bus.out_valid && bus.out_ready;
  assign drainEnd    = outFire && bus.out_last;
  assign drainLen    = inRange ? cntQ[PTR_W-1:0] : DEPTH_P;
  assign drainNext   = drainPtr + IDX_W'(1);
  assign firstLast   = (drainLen == PTR_W'(1));
  assign nextLast    = ((PTR_W'(drainNext) + PTR_W'(1)) == drainLen);
  assign outLoad     = (drainStart && !cntZero) || (outFire && !bus.out_last);
  // The output register is loaded one address ahead, so the RAM read latency never shows on the stream
  assign drainWord   = drainStart ? resbuf[0] : resbuf[drainNext];
  assign bus.cnt     = cntQ;
  assign dbgState    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      LOAD:    if (loadFire && (wrPtr == DEPTH_P - PTR_W'(1))) nextState = SERVE;
      SERVE:   if (bus.write_to_file) nextState = cntZero ? LOAD : DRAIN;
      DRAIN:   if (drainEnd) nextState = LOAD;
      default: nextState = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr          <= '0;
      drainPtr       <= '0;
      cntQ           <= '0;
      bus.load_ready <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.ovf        <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done       <= 1'b0;
      bus.load_ready <= (nextState == LOAD);
      if (loadFire) wrPtr <= wrPtr + PTR_W'(1);
      if ((state == LOAD) && (bus.read_data || bus.store)) bus.ovf <= 1'b1;

      if (serveStrobe) begin
        if (bus.read_data) begin
          if (inRange) begin
            bus.data_out   <= inbuf[cntIdx];
            bus.data_valid <= 1'b1;
          end else begin
            bus.ovf <= 1'b1;
          end
        end
        if (bus.store && !inRange) bus.ovf <= 1'b1;
        if (bus.en_c && (cntQ != '1)) cntQ <= cntQ + CNT_W'(1);
      end

      if (drainStart) begin
        bus.data_valid <= 1'b0;
        drainPtr       <= '0;
        if (cntZero) begin
          bus.done <= 1'b1;
          wrPtr    <= '0;
        end else begin
          bus.out_valid <= 1'b1;
          bus.out_last  <= firstLast;
        end
      end

      if (outLoad) bus.out_data <= drainWord;

      if (outFire) begin
        if (bus.out_last) begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          bus.done      <= 1'b1;
          cntQ          <= '0;
          wrPtr         <= '0;
        end else begin
          drainPtr     <= drainNext;
          bus.out_last <= nextLast;
        end
      end
    end
  end

  // Buffers carry no reset; their contents are only meaningful after a fill / store
  always_ff @(posedge clk) begin
    if (loadFire) inbuf[wrIdx]  <= bus.load_data;
    if (resWrite) resbuf[cntIdx] <= bus.conv_in;
  end

`ifdef RESP_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bus.out_par <= 1'b0;
    else if (outLoad) bus.out_par <= ^drainWord;
  end
`endif
endmodule

// File: tb/tb_conv_data_responder.sv
// Bench for conv_data_responder: random fills and results checked against a buffer/queue model.
module tb_conv_data_responder;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 25;
  localparam int CNT_W  = 32;
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbgState;
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] inbuf_m  [DEPTH];
  logic [DATA_W-1:0] resbuf_m [DEPTH];
  logic [DATA_W-1:0] last_data_m;
  int                cnt_m;
  bit                ovf_m;
  logic [DATA_W-1:0] exp_q [$];

  conv_data_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  conv_data_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got time %0t required < 500000", $time);
    $fatal(1);
  end

  // driver tasks
  task automatic idle_inputs();
    bus.load_valid    = 1'b0;
    bus.load_data     = '0;
    bus.read_data     = 1'b0;
    bus.conv_in       = '0;
    bus.store         = 1'b0;
    bus.en_c          = 1'b0;
    bus.write_to_file = 1'b0;
    bus.out_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt_m = 0;
    ovf_m = 1'b0;
    last_data_m = '0;
  endtask

  task automatic load_words(input int n, input bit seq);
    int i = 0;
    int guard = 0;
    logic [DATA_W-1:0] d;
    while (i < n && guard < 20 * DEPTH) begin
      @(negedge clk);
      guard++;
      d = seq ? DATA_W'(100 + i) : DATA_W'($urandom);
      bus.load_data  = d;
      bus.load_valid = ($urandom_range(0, 3) != 0);
      if (bus.load_valid && bus.load_ready) begin
        inbuf_m[i] = d;
        i++;
      end
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", i, n);
    end
  endtask

  // read strobe, then store (optionally with en_c in the same cycle), then en_c
  task automatic do_item(input bit conv_rand, input bit same_cycle);
    logic [DATA_W-1:0] v;
    @(negedge clk); bus.read_data = 1'b1;
    @(negedge clk); bus.read_data = 1'b0;
    if (cnt_m < DEPTH) last_data_m = inbuf_m[cnt_m];
    else ovf_m = 1'b1;
    checks++;
    if (bus.data_out !== last_data_m || bus.data_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_data cnt=%0d: got data=%0h valid=%b, required data=%0h valid=1",
               cnt_m, bus.data_out, bus.data_valid, last_data_m);
    end
    v = conv_rand ? DATA_W'($urandom) : last_data_m * 2;
    bus.store = 1'b1; bus.conv_in = v; bus.en_c = same_cycle;
    @(negedge clk);
    bus.store = 1'b0; bus.en_c = 1'b0;
    if (cnt_m < DEPTH) resbuf_m[cnt_m] = v;
    else ovf_m = 1'b1;
    if (!same_cycle) begin
      bus.en_c = 1'b1;
      @(negedge clk);
      bus.en_c = 1'b0;
    end
    cnt_m++;
    checks++;
    if (bus.cnt !== CNT_W'(cnt_m) || bus.ovf !== ovf_m) begin
      errors++;
      $display("FAIL item_count: got cnt=%0d ovf=%b, required cnt=%0d ovf=%b", bus.cnt, bus.ovf, cnt_m, ovf_m);
    end
  endtask

  // mode 0: always ready, 1: ready toggles, 2: random ready plus stray write_to_file
  task automatic drain_check(input int mode, input int abort_at);
    int guard = 0;
    int beats = 0;
    int n;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held, e;
    logic held_last;
    exp_q.delete();
    n = (cnt_m < DEPTH) ? cnt_m : DEPTH;
    for (int k = 0; k < n; k++) exp_q.push_back(resbuf_m[k]);
    @(negedge clk); bus.write_to_file = 1'b1;
    while (exp_q.size() > 0 && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.write_to_file = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (beats == abort_at) begin
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.load_ready, bus.data_valid, bus.data_out, bus.cnt, bus.out_valid, bus.out_data,
             bus.out_last, bus.ovf, bus.done} !== '0 || dbgState !== ST_LOAD) begin
          errors++;
          $display("FAIL abort_reset: got out_valid=%b out_data=%0h cnt=%0d state=%0d, required all 0",
                   bus.out_valid, bus.out_data, bus.cnt, dbgState);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        cnt_m = 0;
        ovf_m = 1'b0;
        return;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (guard % 2 == 1);
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_drop: beat %0d got out_valid=%b, required 1", beats, bus.out_valid);
      end else begin
        if (stalled) begin
          checks++;
          if (bus.out_data !== held || bus.out_last !== held_last) begin
            errors++;
            $display("FAIL stall_hold: got %0h/%b, required %0h/%b", bus.out_data, bus.out_last, held, held_last);
          end
        end
        if (bus.out_ready) begin
          e = exp_q.pop_front();
          beats++;
          stalled = 1'b0;
          checks++;
          if (bus.out_data !== e || bus.out_last !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL beat %0d: got data=%0h last=%b, required data=%0h last=%b",
                     beats, bus.out_data, bus.out_last, e, (exp_q.size() == 0));
          end
`ifdef RESP_PARITY_EN
          checks++;
          if (bus.out_par !== ^e) begin
            errors++;
            $display("FAIL parity beat %0d: got %b, required %b", beats, bus.out_par, ^e);
          end
`endif
        end else begin
          stalled   = 1'b1;
          held      = bus.out_data;
          held_last = bus.out_last;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats left, required 0", exp_q.size());
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.write_to_file = 1'b0;
    cnt_m = 0;
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.cnt !== '0 || dbgState !== ST_LOAD) begin
      errors++;
      $display("FAIL drain_done: got done=%b out_valid=%b cnt=%0d state=%0d, required 1 0 0 %0d",
               bus.done, bus.out_valid, bus.cnt, dbgState, ST_LOAD);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.load_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b load_ready=%b out_valid=%b, required 0 1 0",
               bus.done, bus.load_ready, bus.out_valid);
    end
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.load_ready, bus.data_valid, bus.data_out, bus.cnt, bus.out_valid, bus.out_data,
         bus.out_last, bus.ovf, bus.done} !== '0 || dbgState !== ST_LOAD) begin
      errors++;
      $display("FAIL reset_outputs: got load_ready=%b cnt=%0d ovf=%b state=%0d, required all 0",
               bus.load_ready, bus.cnt, bus.ovf, dbgState);
    end
    rst = 1'b0;
    cnt_m = 0; ovf_m = 1'b0; last_data_m = '0;
    @(negedge clk);
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got load_ready=%b, required 1", bus.load_ready);
    end
  endtask

  task automatic test_basic();
    load_words(DEPTH, 1'b1);
    checks++;
    if (dbgState !== ST_SERVE || bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_full: got state=%0d load_ready=%b, required %0d 0", dbgState, bus.load_ready, ST_SERVE);
    end
    for (int i = 0; i < DEPTH; i++) do_item(1'b0, 1'b0);
    drain_check(0, -1);
  endtask

  task automatic test_stall();
    load_words(DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_item(1'b1, 1'(($urandom_range(0, 1))));
    drain_check(1, -1);
  endtask

  task automatic test_back_to_back();
    load_words(DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_item(1'b1, 1'(($urandom_range(0, 1))));
    drain_check(2, -1);
  endtask

  task automatic test_partial();
    load_words(DEPTH, 1'b0);
    for (int i = 0; i < 5; i++) do_item(1'b1, (i == 3));
    drain_check(0, -1);
    load_words(DEPTH, 1'b0);
    drain_check(0, -1);
  endtask

  task automatic test_overflow();
    do_reset();
    load_words(10, 1'b0);
    @(negedge clk); bus.read_data = 1'b1;
    @(negedge clk); bus.read_data = 1'b0;
    checks++;
    if (bus.ovf !== 1'b1 || bus.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_read_ovf: got ovf=%b data_valid=%b, required 1 0", bus.ovf, bus.data_valid);
    end
    do_reset();
    load_words(DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_item(1'b1, 1'b0);
    @(negedge clk); bus.store = 1'b1; bus.conv_in = DATA_W'($urandom);
    @(negedge clk); bus.store = 1'b0;
    ovf_m = 1'b1;
    checks++;
    if (bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL store_ovf: got ovf=%b, required 1", bus.ovf);
    end
    do_item(1'b1, 1'b0);
    drain_check(1, -1);
  endtask

  task automatic test_abort();
    do_reset();
    load_words(DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_item(1'b1, 1'b0);
    drain_check(2, 7);
    load_words(DEPTH, 1'b0);
    drain_check(0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_partial();
    test_overflow();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
